// File: rtl/spi_master_driver_if.sv
// spi_master_driver_if
// Groups the byte-stream handshake, the received-byte strobe and the SPI pins
// of spi_master_driver into one bundle.
//   master modport : the SPI master itself (drives SCK/CS/PICO, accepts bytes)
//   slave modport  : the client feeding bytes in and watching received bytes
// Signals:
//   tx_data_i/tx_last_i/tx_valid_i/tx_ready_o : byte stream into the master
//   rx_data_o/rx_valid_o                      : received byte, one-cycle strobe
//   busy_o                                    : frame in progress (incl. CS gap)
//   spi_sck_o/spi_cs_no/spi_tx_o/spi_rx_i     : SPI pins, mode 0
interface spi_master_driver_if;
  logic [7:0] tx_data_i;
  logic       tx_last_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       busy_o;
  logic       spi_sck_o;
  logic       spi_cs_no;
  logic       spi_tx_o;
  logic       spi_rx_i;

  modport master (
    input  tx_data_i, tx_last_i, tx_valid_i, spi_rx_i,
    output tx_ready_o, rx_data_o, rx_valid_o, busy_o,
           spi_sck_o, spi_cs_no, spi_tx_o
  );

  modport slave (
    output tx_data_i, tx_last_i, tx_valid_i, spi_rx_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, busy_o,
           spi_sck_o, spi_cs_no, spi_tx_o
  );
endinterface

// File: rtl/spi_master_driver.sv
// spi_master_driver
// SPI mode-0 master. Serialises a framed byte stream MSB first on PICO under a
// single chip-select assertion, capturing POCI bytes in parallel. SCK phases
// last HALF system clocks, HALF = ceil(CLK_MHZ / (2*SCK_MHZ)), minimum 1.
// Ports:
//   clk_i    : system clock
//   reset_i  : synchronous active-high reset, aborts any frame immediately
//   bus      : spi_master_driver_if.master (byte stream, rx strobe, SPI pins)
module spi_master_driver #(
  parameter int CLK_MHZ = 64,
  parameter int SCK_MHZ = 24
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  spi_master_driver_if.master   bus
);

  localparam int HALF_CEIL = (CLK_MHZ + 2 * SCK_MHZ - 1) / (2 * SCK_MHZ);
  localparam int HALF      = (HALF_CEIL < 1) ? 1 : HALF_CEIL;
  localparam int PH_W      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, NEXT, HOLD, GAP} state_t;

  state_t          state;
  logic [PH_W-1:0] ph;
  logic [2:0]      bit_cnt;
  logic            last_q;
  logic            cs_n;
  logic            sck;
  logic            pico;
  logic            ready;
  logic            rx_vld;
  logic [7:0]      rx_byte;
  logic            busy;
  logic [7:0]      tx_sh;
  logic [7:0]      rx_sh;

  logic       phase_done;
  logic       accept;
  logic       shift_tx;
  logic       sample_rx;
  logic [7:0] rx_shifted;

  assign phase_done = (ph == PH_LAST);
  // ready is only ever high in IDLE and in NEXT of a non-last byte
  assign accept     = bus.tx_valid_i & ready;
  assign shift_tx   = (state == HIGH) & phase_done & (bit_cnt != 3'd7);
  // POCI is captured on the first cycle SCK is high (the rising edge)
  assign sample_rx  = (state == HIGH) & (ph == '0);
  assign rx_shifted = {rx_sh[6:0], bus.spi_rx_i};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      ph      <= '0;
      bit_cnt <= '0;
      last_q  <= 1'b0;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      pico    <= 1'b0;
      ready   <= 1'b1;
      rx_vld  <= 1'b0;
      rx_byte <= '0;
      busy    <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            last_q  <= bus.tx_last_i;
            pico    <= bus.tx_data_i[7];
            cs_n    <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            ph      <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (phase_done) begin
            ph    <= '0;
            sck   <= 1'b1;
            state <= HIGH;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        HIGH: begin
          if (phase_done) begin
            ph      <= '0;
            sck     <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              // with HALF=1 the final sample lands on this same edge
              rx_byte <= (ph == '0) ? rx_shifted : rx_sh;
              rx_vld  <= 1'b1;
              ready   <= ~last_q;
              state   <= NEXT;
            end else begin
              pico  <= tx_sh[6];
              state <= LOW;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        NEXT: begin
          if (last_q) begin
            ph    <= '0;
            state <= HOLD;
          end else if (accept) begin
            // next byte: bit7 goes out now, then a normal low phase
            last_q <= bus.tx_last_i;
            pico   <= bus.tx_data_i[7];
            ready  <= 1'b0;
            ph     <= '0;
            state  <= LOW;
          end
        end
        HOLD: begin
          if (phase_done) begin
            ph    <= '0;
            cs_n  <= 1'b1;
            state <= GAP;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        GAP: begin
          if (phase_done) begin
            ph    <= '0;
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // shift registers carry data only; their contents are don't-care until loaded
  always_ff @(posedge clk_i) begin
    if (accept) begin
      tx_sh <= bus.tx_data_i;
    end else if (shift_tx) begin
      tx_sh <= {tx_sh[6:0], 1'b0};
    end
    if (sample_rx) begin
      rx_sh <= rx_shifted;
    end
  end

  assign bus.tx_ready_o = ready;
  assign bus.rx_data_o  = rx_byte;
  assign bus.rx_valid_o = rx_vld;
  assign bus.busy_o     = busy;
  assign bus.spi_sck_o  = sck;
  assign bus.spi_cs_no  = cs_n;
  assign bus.spi_tx_o   = pico;

endmodule

// File: tb/tb_spi_master_driver.sv
// tb_spi_master_driver
// Scoreboard bench for spi_master_driver. Stimulus pushes expected PICO bytes,
// expected POCI bytes and expected SCK edge counts into queues; monitor
// processes decode the SPI pins and the rx strobe and pop/compare.
// dut0: default parameters (HALF=2) with a target model or loopback on POCI.
// dut1: CLK_MHZ=8, SCK_MHZ=4 (HALF=1) in loopback.
module tb_spi_master_driver;

  localparam int HALF0 = 2;  // ceil(64 / 48)
  localparam int HALF1 = 1;  // ceil(8 / 8)

  logic clk;
  logic rst;

  spi_master_driver_if bus0 ();
  spi_master_driver_if bus1 ();

  spi_master_driver dut0 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus0)
  );

  spi_master_driver #(.CLK_MHZ(8), .SCK_MHZ(4)) dut1 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  // Scoreboard queues
  int tgt_q[$];
  int rx_q[$];
  int edge_q[$];
  int rx1_q[$];

  // POCI source for dut0
  logic       loop_mode;
  logic [7:0] resp_byte;
  logic [2:0] resp_idx;
  logic       tgt_en;

  always_comb bus0.spi_rx_i = loop_mode ? bus0.spi_tx_o : resp_byte[resp_idx];
  always_comb bus1.spi_rx_i = bus1.spi_tx_o;

  // Target/timing monitor for dut0
  logic       prev_cs, prev_sck, first_rise;
  int         rises, nbits, hi_cnt, lo_cnt, cs_hi_cnt, frames;
  logic [7:0] tgt_sh;

  always @(negedge clk) begin
    if (rst || !tgt_en) begin
      prev_cs    = 1'b1;
      prev_sck   = 1'b0;
      first_rise = 1'b0;
      rises      = 0;
      nbits      = 0;
      hi_cnt     = 0;
      lo_cnt     = 0;
      cs_hi_cnt  = 0;
      frames     = 0;
      resp_idx   = 3'd7;
    end else begin
      if (!bus0.spi_cs_no) begin
        if (prev_cs) begin
          if (frames > 0) chk_ge("cs_high_gap", cs_hi_cnt, HALF0);
          rises = 0; nbits = 0; lo_cnt = 0; hi_cnt = 0;
          first_rise = 1'b1;
          resp_idx = 3'd7;
        end
        if (bus0.spi_sck_o && !prev_sck) begin
          if (first_rise) chk_ge("cs_setup", lo_cnt, HALF0);
          else            chk_ge("sck_low", lo_cnt, HALF0);
          first_rise = 1'b0;
          rises++;
          hi_cnt = 0;
          tgt_sh = {tgt_sh[6:0], bus0.spi_tx_o};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            if (tgt_q.size() == 0) bad("tgt_byte");
            else chk("tgt_byte", int'(tgt_sh), tgt_q.pop_front());
          end
        end
        if (!bus0.spi_sck_o && prev_sck) begin
          chk("sck_high", hi_cnt, HALF0);
          lo_cnt = 0;
          resp_idx = resp_idx - 3'd1;
        end
        if (bus0.spi_sck_o) hi_cnt++;
        else                lo_cnt++;
      end else begin
        if (!prev_cs) begin
          chk_ge("cs_hold", lo_cnt, HALF0);
          if (edge_q.size() == 0) bad("sck_edges");
          else chk("sck_edges", rises, edge_q.pop_front());
          frames++;
          cs_hi_cnt = 0;
        end
        cs_hi_cnt++;
      end
      prev_cs  = bus0.spi_cs_no;
      prev_sck = bus0.spi_sck_o;
    end
  end

  // Received-byte scoreboard, dut0
  always @(negedge clk) begin
    if (bus0.rx_valid_o === 1'b1) begin
      if (rx_q.size() == 0) bad("rx_byte");
      else chk("rx_byte", int'(bus0.rx_data_o), rx_q.pop_front());
    end
  end

  // Monitor and scoreboard for dut1 (HALF=1)
  logic prev_sck1;
  int   hi1, rises1;

  always @(negedge clk) begin
    if (rst) begin
      prev_sck1 = 1'b0;
      hi1       = 0;
      rises1    = 0;
    end else begin
      if (bus1.spi_sck_o && !prev_sck1) begin
        hi1 = 0;
        rises1++;
      end
      if (!bus1.spi_sck_o && prev_sck1) chk("h1_sck_high", hi1, HALF1);
      if (bus1.spi_sck_o) hi1++;
      prev_sck1 = bus1.spi_sck_o;
    end
    if (bus1.rx_valid_o === 1'b1) begin
      if (rx1_q.size() == 0) bad("h1_rx_byte");
      else chk("h1_rx_byte", int'(bus1.rx_data_o), rx1_q.pop_front());
    end
  end

  // Drivers
  task automatic send0(input logic [7:0] d, input logic l);
    int n = 0;
    bus0.tx_data_i  = d;
    bus0.tx_last_i  = l;
    bus0.tx_valid_i = 1'b1;
    while (bus0.tx_ready_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) bad("send0_timeout");
    @(posedge clk);
    #1;
    bus0.tx_valid_i = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, input logic l);
    int n = 0;
    bus1.tx_data_i  = d;
    bus1.tx_last_i  = l;
    bus1.tx_valid_i = 1'b1;
    while (bus1.tx_ready_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) bad("send1_timeout");
    @(posedge clk);
    #1;
    bus1.tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle0();
    int n = 0;
    @(negedge clk);
    while (bus0.busy_o !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) bad("idle0_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle1();
    int n = 0;
    @(negedge clk);
    while (bus1.busy_o !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) bad("idle1_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int nbytes, input logic [7:0] rx_single);
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    for (int i = 0; i < nbytes; i++) begin
      tgt_q.push_back(int'(bytes[i]));
      if (loop_mode) rx_q.push_back(int'(bytes[i]));
    end
    if (!loop_mode) rx_q.push_back(int'(rx_single));
    edge_q.push_back(8 * nbytes);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus0.tx_data_i = '0; bus0.tx_last_i = 1'b0; bus0.tx_valid_i = 1'b0;
    bus1.tx_data_i = '0; bus1.tx_last_i = 1'b0; bus1.tx_valid_i = 1'b0;
    loop_mode = 1'b1;
    resp_byte = 8'h00;
    tgt_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    chk("rst_cs_n",     int'(bus0.spi_cs_no),  1);
    chk("rst_sck",      int'(bus0.spi_sck_o),  0);
    chk("rst_pico",     int'(bus0.spi_tx_o),   0);
    chk("rst_ready",    int'(bus0.tx_ready_o), 1);
    chk("rst_rx_valid", int'(bus0.rx_valid_o), 0);
    chk("rst_rx_data",  int'(bus0.rx_data_o),  0);
    chk("rst_busy",     int'(bus0.busy_o),     0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 4-byte write frame, loopback
    push_frame(8'h41, 8'h5A, 8'hE8, 8'h0F, 4, 8'h00);
    send0(8'h41, 1'b0);
    chk("busy_in_frame", int'(bus0.busy_o), 1);
    send0(8'h5A, 1'b0);
    send0(8'hE8, 1'b0);
    send0(8'h0F, 1'b1);
    wait_idle0();

    // single-byte frame, target answers 0xA5
    loop_mode = 1'b0;
    resp_byte = 8'hA5;
    push_frame(8'hC0, 8'h00, 8'h00, 8'h00, 1, 8'hA5);
    send0(8'hC0, 1'b1);
    wait_idle0();
    loop_mode = 1'b1;

    // 3-byte frame with a 10-cycle stall after byte 1
    push_frame(8'h12, 8'h34, 8'h56, 8'h00, 3, 8'h00);
    send0(8'h12, 1'b0);
    begin
      int n = 0;
      @(negedge clk);
      while (bus0.tx_ready_o !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) bad("stall_ready_timeout");
    end
    repeat (10) begin
      @(negedge clk);
      chk("stall_cs_n", int'(bus0.spi_cs_no), 0);
      chk("stall_sck",  int'(bus0.spi_sck_o), 0);
    end
    send0(8'h34, 1'b0);
    send0(8'h56, 1'b1);
    wait_idle0();

    // reset mid-frame aborts without an rx strobe
    tgt_en = 1'b0;
    send0(8'h3C, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_cs_n",     int'(bus0.spi_cs_no),  1);
    chk("abort_sck",      int'(bus0.spi_sck_o),  0);
    chk("abort_ready",    int'(bus0.tx_ready_o), 1);
    chk("abort_rx_valid", int'(bus0.rx_valid_o), 0);
    chk("abort_busy",     int'(bus0.busy_o),     0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tgt_en = 1'b1;

    // recovery frame after abort
    push_frame(8'h99, 8'h00, 8'h00, 8'h00, 1, 8'h00);
    send0(8'h99, 1'b1);
    wait_idle0();

    // HALF=1 instance, 2-byte loopback frame
    rx1_q.push_back(32'hA3);
    rx1_q.push_back(32'h5C);
    send1(8'hA3, 1'b0);
    send1(8'h5C, 1'b1);
    wait_idle1();

    repeat (4) @(posedge clk);
    #1;
    chk("h1_rises",   rises1, 16);
    chk("tgt_q_left", tgt_q.size(), 0);
    chk("rx_q_left",  rx_q.size(), 0);
    chk("edge_q_left", edge_q.size(), 0);
    chk("rx1_q_left", rx1_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_driver.md
Name: spi_master_driver

Overview:
- SPI mode-0 master: serialises a framed stream of bytes onto SCK/PICO (MSB first) under one chip-select assertion and captures POCI bytes in parallel.
- Used by bus-bridge test/driver logic to issue variable-length command frames of 1–4+ bytes, e.g. {cmd, data, addr_hi, addr_lo}, {cmd, addr_hi, addr_lo} or {cmd}, to the SPI target port of the PET FPGA.
- SCK is derived from the system clock by an integer divider.

Parameters:
- CLK_MHZ, 64, system clock frequency in MHz.
- SCK_MHZ, 24, maximum SPI clock frequency in MHz.
- Derived HALF = ceil(CLK_MHZ / (2*SCK_MHZ)), minimum 1 (defaults give 2, so SCK = 16 MHz). Each SCK phase lasts HALF clk_i cycles.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- tx_data_i  in  8  byte to transmit
- tx_last_i  in  1  byte is the final byte of the frame
- tx_valid_i  in  1  tx_data_i/tx_last_i valid
- tx_ready_o  out  1  byte accepted this cycle when tx_valid_i & tx_ready_o
- rx_data_o  out  8  byte shifted in from spi_rx_i
- rx_valid_o  out  1  one-cycle pulse, rx_data_o valid
- busy_o  out  1  high from frame start until CS gap completes
- spi_sck_o  out  1  SPI clock, idle low (CPOL=0)
- spi_cs_no  out  1  chip select, active low
- spi_tx_o  out  1  PICO data
- spi_rx_i  in  1  POCI data

Behaviour:
- Reset (sync, priority over all): state=IDLE, spi_cs_no=1, spi_sck_o=0, spi_tx_o=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, busy_o=0. Reset mid-frame aborts immediately: CS deasserts next edge, no rx_valid_o is emitted.
- States: IDLE, SETUP, LOW, HIGH, NEXT, HOLD, GAP.
- IDLE:
  - tx_ready_o=1.
  - On accept: load shift reg, latch last flag, spi_cs_no<=0, spi_tx_o<=bit7, go SETUP.
- SETUP: wait HALF cycles with SCK low (CS-to-first-edge setup), then go HIGH.
- HIGH:
  - Entry sets spi_sck_o=1.
  - Sample spi_rx_i into rx shift reg on the entry (rising-edge) cycle.
  - Hold HALF cycles, then spi_sck_o<=0 and go LOW, or go NEXT if 8 bits are done.
- LOW:
  - Entry shifts the next tx bit onto spi_tx_o (change on falling edge).
  - Hold HALF cycles, then go HIGH.
- NEXT (byte complete, SCK low):
  - Pulse rx_valid_o for 1 cycle with the full byte; the first received bit is rx_data_o[7].
  - If latched last: go HOLD.
  - Else tx_ready_o=1. On accept, load the byte, drive bit7 and go LOW-equivalent timing (HALF cycles before the next rise). Without accept, remain in NEXT with CS low and SCK low (stall; no timeout).
- HOLD: HALF cycles SCK low, then spi_cs_no<=1, go GAP.
- GAP: CS high for HALF cycles minimum, then IDLE; busy_o drops on entry to IDLE.
- tx_ready_o=0 in all states except IDLE and NEXT(non-last).
- Bit count 3-bit counter wraps 7->0 per byte. Phase counter counts 0..HALF-1.
- spi_tx_o retains its last driven value between bytes and after the frame; it is don't-care while CS is high.
- Frame length is unbounded; only tx_last_i ends the frame.
- tx_valid_i is ignored when tx_ready_o=0; a 1-byte frame (tx_last_i=1 on the first byte) is legal.

Test Plan:
- Reset: assert reset_i mid-frame -> next cycle spi_cs_no=1, spi_sck_o=0, tx_ready_o=1, no rx_valid_o.
- Write frame {0x41,0x5A,0xE8,0x0F} with tx_last_i on the 4th byte (loopback spi_tx_o->spi_rx_i):
  - 32 SCK rising edges with a single CS low.
  - A target model decodes 0x41,0x5A,0xE8,0x0F, MSB first.
  - rx_valid_o fires 4 times with the same bytes.
- SCK timing at defaults: each high and low phase = 2 clk_i cycles; first rise ≥2 cycles after CS falls; CS rises ≥2 cycles after the last fall; CS high ≥2 cycles before the next frame.
- Single-byte frame 0xC0 with tx_last_i=1 and spi_rx_i tied to a target returning 0xA5 -> 8 SCK edges, rx_data_o=0xA5.
- Stall: withhold tx_valid_i for 10 cycles after byte 1 of a 3-byte frame -> CS stays low, SCK low, no extra edges; frame resumes correctly.
- Parameter CLK_MHZ=8, SCK_MHZ=4 -> HALF=1; SCK toggles every cycle; data integrity holds.
